// File: rtl/trigger_ctrl_pkg.sv
// Shared types for the multi-channel trigger controller: one-hot FSM states
// and combine-mode constants.
package trigger_ctrl_pkg;

  typedef enum logic [5:0] {
    OFF      = 6'b000001,
    ARMED    = 6'b000010,
    FIRED    = 6'b000100,
    HOLDOFF  = 6'b001000,
    CLEAR    = 6'b010000,
    WAIT_RST = 6'b100000
  } trig_state_t;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_AND = 1'b1;

endpackage

// File: rtl/trigger_control_mc_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous bit, with a registered
// previous copy of the synchronised level for rising-edge detection.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic module_reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/trigger_control_mc.sv
// Multi-channel trigger controller: synchronise, qualify, fire, holdoff, clear.
// Optional free-running timestamp latch enabled by `define TRIG_TIMESTAMP_EN.
module trigger_control_mc
  import trigger_ctrl_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned HOLDOFF_W   = 8,
  parameter int unsigned CLR_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 module_reset_n,
  input  logic [N_CH-1:0]      trig_in,
  input  logic [N_CH-1:0]      ch_enable,
  input  logic                 mode,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  input  logic                 armed,
  input  logic                 auto_rearm,
  input  logic                 manual_rearm,
  input  logic                 manual_trigger,
  output logic                 triggered_out,
  output logic [N_CH-1:0]      trig_source,
  output logic [N_CH-1:0]      comp_reset,
  output logic                 busy,
  output logic                 clear_fault,
  output logic [CNT_W-1:0]     trig_count,
  output logic [CNT_W-1:0]     trig_timestamp
);

  localparam int unsigned CLR_W = $clog2(CLR_TIMEOUT + 1);

  logic [N_CH-1:0] level, rise;
  logic [3:0]      ctl_async, ctl_level, ctl_rise;
  logic            armed_s, auto_s, mrearm_rise, mtrig_rise;
  logic            unused_ctl;

  for (genvar i = 0; i < N_CH; i++) begin : g_trig_sync
    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .module_reset_n(module_reset_n), .async_in(trig_in[i]),
      .level(level[i]), .rise(rise[i])
    );
  end

  assign ctl_async = {manual_trigger, manual_rearm, auto_rearm, armed};
  for (genvar j = 0; j < 4; j++) begin : g_ctl_sync
    sync_edge_detect #(.STAGES(2)) u_sync (
      .clk(clk), .module_reset_n(module_reset_n), .async_in(ctl_async[j]),
      .level(ctl_level[j]), .rise(ctl_rise[j])
    );
  end

  assign armed_s     = ctl_level[0];
  assign auto_s      = ctl_level[1];
  assign mrearm_rise = ctl_rise[2];
  assign mtrig_rise  = ctl_rise[3];
  assign unused_ctl  = ^{ctl_level[3:2], ctl_rise[1:0]};

  trig_state_t          state, state_nx;
  logic [HOLDOFF_W-1:0] hold_cnt, hold_cnt_nx;
  logic [CLR_W-1:0]     clr_cnt, clr_cnt_nx;
  logic [N_CH-1:0]      en_lvl, en_rise, src_nx;
  logic                 cond, pulse, fault_nx;

  assign en_lvl  = ch_enable & level;
  assign en_rise = ch_enable & rise;

  // AND mode: every enabled channel is high and at least one of them just rose.
  always_comb begin
    if (mode == MODE_AND)
      cond = (ch_enable != '0) && (en_lvl == ch_enable) && (en_rise != '0);
    else
      cond = (en_rise != '0);
  end

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    clr_cnt_nx  = clr_cnt;
    fault_nx    = clear_fault;
    src_nx      = trig_source;
    pulse       = mtrig_rise;
    unique case (state)
      OFF: begin
        if (armed_s && (en_lvl == '0)) state_nx = ARMED;
      end
      ARMED: begin
        if (cond || mtrig_rise) begin
          state_nx = FIRED;
          pulse    = 1'b1;
          src_nx   = cond ? en_rise : '0;
        end else if (!armed_s) begin
          state_nx = OFF;
        end
      end
      FIRED: begin
        state_nx    = HOLDOFF;
        hold_cnt_nx = holdoff_cycles;
      end
      HOLDOFF: begin
        if (hold_cnt == '0) begin
          state_nx   = CLEAR;
          clr_cnt_nx = '0;
        end else begin
          hold_cnt_nx = hold_cnt - 1'b1;
        end
      end
      CLEAR: begin
        if (en_lvl == '0) begin
          state_nx = auto_s ? OFF : WAIT_RST;
        end else if (clr_cnt == CLR_W'(CLR_TIMEOUT - 1)) begin
          state_nx = WAIT_RST;
          fault_nx = 1'b1;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      WAIT_RST: begin
        if (mrearm_rise) begin
          state_nx = OFF;
          fault_nx = 1'b0;
        end else if (!armed_s) begin
          state_nx = OFF;
        end
      end
      default: state_nx = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      state         <= OFF;
      hold_cnt      <= '0;
      clr_cnt       <= '0;
      triggered_out <= 1'b0;
      trig_source   <= '0;
      clear_fault   <= 1'b0;
      trig_count    <= '0;
    end else begin
      state         <= state_nx;
      hold_cnt      <= hold_cnt_nx;
      clr_cnt       <= clr_cnt_nx;
      triggered_out <= pulse;
      trig_source   <= src_nx;
      clear_fault   <= fault_nx;
      if (pulse && (trig_count != '1)) trig_count <= trig_count + 1'b1;
    end
  end

  assign comp_reset = (state == CLEAR) ? en_lvl : '0;
  assign busy       = (state == FIRED) || (state == HOLDOFF) ||
                      (state == CLEAR) || (state == WAIT_RST);

`ifdef TRIG_TIMESTAMP_EN
  logic [CNT_W-1:0] free_cnt;

  always_ff @(posedge clk or negedge module_reset_n) begin
    if (!module_reset_n) begin
      free_cnt       <= '0;
      trig_timestamp <= '0;
    end else begin
      free_cnt <= free_cnt + 1'b1;
      if (pulse) trig_timestamp <= free_cnt;
    end
  end
`else
  assign trig_timestamp = '0;
`endif

endmodule
